// File: rtl/multi_miner_ctrl_if.sv
// Host command, lane issue/result and found-nonce signals of multi_miner_ctrl.
// The slave modport is the controller side; the master modport is the host/lane side.
interface multi_miner_ctrl_if #(
  parameter int LANES = 4
);
  logic                  start;
  logic [31:0]           nonce_start;
  logic [31:0]           nonce_end;
  logic                  abort;
  logic                  issue;
  logic [LANES-1:0]      issue_mask;
  logic [LANES*32-1:0]   issue_nonce;
  logic [LANES-1:0]      res_valid;
  logic [LANES-1:0]      res_hit;
  logic                  found_valid;
  logic [31:0]           found_nonce;
  logic                  found_ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, nonce_start, nonce_end, abort, res_valid, res_hit, found_ready,
    input  issue, issue_mask, issue_nonce, found_valid, found_nonce, busy, done, overflow
  );

  modport slave (
    input  start, nonce_start, nonce_end, abort, res_valid, res_hit, found_ready,
    output issue, issue_mask, issue_nonce, found_valid, found_nonce, busy, done, overflow
  );
endinterface

// File: rtl/multi_miner_ctrl.sv
// Splits a nonce range across LANES hash lanes, collects hits into a first-word fall-through FIFO.
// First issue 1 cycle after start, then every THROUGHPUT cycles; stalls on a saturated lane, hits wait in pending regs while the FIFO is full.
module multi_miner_ctrl #(
  parameter int LANES      = 4,
  parameter int THROUGHPUT = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 64
) (
  input  logic              clk,
  input  logic              rst,
  multi_miner_ctrl_if.slave bus
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [OW-1:0] OUTST_ONE = OW'(1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [32:0]   LANES33   = 33'(LANES);
  localparam logic [31:0]   LANES32   = 32'(LANES);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(THROUGHPUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              aborted_q, aborted_d;
  logic [32:0]       base_q, base_d;
  logic [31:0]       end_q, end_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     outst_q [LANES];
  logic [OW-1:0]     outst_d [LANES];
  logic [31:0]       ret_q   [LANES];
  logic [31:0]       ret_d   [LANES];
  logic [LANES-1:0]  pend_vld_q, pend_vld_d;
  logic [31:0]       pend_q  [LANES];
  logic [31:0]       pend_d  [LANES];
  logic [31:0]       mem_q   [FIFO_DEPTH];
  logic [31:0]       mem_d   [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic [32:0]       lane_base [LANES];
  logic [LANES-1:0]  lane_in_range, res_ok;
  logic [LANES*32-1:0] issue_nonce_w;
  logic              stall, all_clear;
  logic              issue_fire, capture_en;
  logic              fifo_full, fifo_empty, push, pop;
  logic [SW-1:0]     sel;

  // Per-lane view: nonce/range of the next issue, valid results, stall and drain status.
  always_comb begin
    lane_base     = '{default: '0};
    lane_in_range = '0;
    res_ok        = '0;
    issue_nonce_w = '0;
    stall         = 1'b0;
    all_clear     = (pend_vld_q == '0);
    sel           = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_base[k]     = base_q + 33'(k);
      lane_in_range[k] = (lane_base[k] <= {1'b0, end_q});
      res_ok[k]        = bus.res_valid[k] && (outst_q[k] != '0);
      if (lane_in_range[k] && (outst_q[k] == OUTST_MAX)) stall = 1'b1;
      if (outst_q[k] != '0) all_clear = 1'b0;
      if (issue_fire) issue_nonce_w[32*k +: 32] = lane_base[k][31:0];
    end
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pend_vld_q[k]) sel = SW'(k);
    end
  end

  assign issue_fire = (state_q == RUN) && (cnt_q == '0) && !stall && !bus.abort;
  assign capture_en = ((state_q == RUN) || ((state_q == DRAIN) && !aborted_q)) && !bus.abort;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && bus.found_ready;
  assign push       = (pend_vld_q != '0) && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    aborted_d  = aborted_q;
    base_d     = base_q;
    end_d      = end_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    ret_d      = ret_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    done_d     = (state_q == DONE);

    for (int k = 0; k < LANES; k++) begin
      if (issue_fire && lane_in_range[k] && !res_ok[k])
        outst_d[k] = outst_q[k] + OUTST_ONE;
      else if (!(issue_fire && lane_in_range[k]) && res_ok[k])
        outst_d[k] = outst_q[k] - OUTST_ONE;
      if (res_ok[k]) ret_d[k] = ret_q[k] + LANES32;
    end

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = pend_q[sel];
      pend_vld_d[sel]         = 1'b0;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    // An occupied pending slot loses the new hit even if it drains this same cycle.
    for (int k = 0; k < LANES; k++) begin
      if (capture_en && res_ok[k] && bus.res_hit[k]) begin
        if (pend_vld_q[k]) begin
          overflow_d = 1'b1;
        end else begin
          pend_vld_d[k] = 1'b1;
          pend_d[k]     = ret_q[k];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d     = {1'b0, bus.nonce_start};
          end_d      = bus.nonce_end;
          cnt_d      = '0;
          aborted_d  = 1'b0;
          overflow_d = 1'b0;
          pend_vld_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          for (int k = 0; k < LANES; k++) begin
            outst_d[k] = '0;
            ret_d[k]   = bus.nonce_start + 32'(k);
          end
          state_d = (bus.nonce_end >= bus.nonce_start) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else if (issue_fire) begin
          base_d = base_q + LANES33;
          cnt_d  = CNT_RELOAD;
          // The 33-bit base cannot wrap, so an end of 0xFFFFFFFF still terminates.
          if ((base_q + LANES33) > {1'b0, end_q}) state_d = DRAIN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRAIN: begin
        if (bus.abort) aborted_d = 1'b1;
        if (all_clear) state_d = (aborted_q || bus.abort) ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aborted_q  <= 1'b0;
      base_q     <= '0;
      end_q      <= '0;
      cnt_q      <= '0;
      outst_q    <= '{default: '0};
      ret_q      <= '{default: '0};
      pend_vld_q <= '0;
      pend_q     <= '{default: '0};
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aborted_q  <= aborted_d;
      base_q     <= base_d;
      end_q      <= end_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      ret_q      <= ret_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.issue       = issue_fire;
  assign bus.issue_mask  = issue_fire ? lane_in_range : '0;
  assign bus.issue_nonce = issue_nonce_w;
  assign bus.found_valid = !fifo_empty;
  assign bus.found_nonce = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/multi_miner_ctrl.md
MULTI_MINER_CTRL -- requirements
Module: multi_miner_ctrl

Interface
REQ-001 Parameter LANES, default 4: number of parallel hash lanes; legal range 1..16.
REQ-002 Parameter THROUGHPUT, default 8: cycles between issue strobes; legal range 1..127.
REQ-003 Parameter FIFO_DEPTH, default 4: found-nonce FIFO entries; power of 2, at least 2.
REQ-004 Parameter MAX_OUTST, default 64: maximum outstanding issues per lane.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; loads the nonce range; honoured only in IDLE.
REQ-008 nonce_start  in  32  first nonce of the range; sampled on an accepted start.
REQ-009 nonce_end  in  32  last nonce of the range, inclusive; sampled on an accepted start.
REQ-010 abort  in  1  one-cycle pulse; stops issuing and discards any further hits.
REQ-011 issue  out  1  issue strobe shared by all lanes.
REQ-012 issue_mask  out  LANES  bit k high means lane k is issued on this strobe.
REQ-013 issue_nonce  out  LANES*32  lane k nonce in bits [32k+31:32k].
REQ-014 res_valid  in  LANES  per-lane result strobe; results arrive in issue order.
REQ-015 res_hit  in  LANES  per-lane hash meets target; qualified by res_valid.
REQ-016 found_valid  out  1  FIFO head is valid.
REQ-017 found_nonce  out  32  FIFO head nonce.
REQ-018 found_ready  in  1  pops the FIFO head when found_valid is high.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 done  out  1  one-cycle pulse when the range completes normally.
REQ-021 overflow  out  1  sticky flag for a lost hit; cleared only by rst or by an accepted start.

Function
REQ-022 States:
- IDLE -> RUN on start, if nonce_end >= nonce_start.
- IDLE -> DONE on start, if nonce_end < nonce_start (empty range).
- RUN -> DRAIN once the last nonce has been issued, or on abort.
- DRAIN -> DONE when every lane has zero outstanding issues and all pending hits are in the FIFO; after an abort, DRAIN -> IDLE instead, skipping DONE.
- DONE -> IDLE after 1 cycle, pulsing done.
REQ-023 Issue base register: 33 bits, loaded with nonce_start on an accepted start; it cannot wrap, so nonce_end = 0xFFFFFFFF terminates correctly.
REQ-024 RUN issue cadence:
- First issue pulses 1 cycle after the accepted start, then every THROUGHPUT cycles.
- Each issue carries issue_nonce lane k = base+k and issue_mask[k] = (base+k <= nonce_end); then base increments by LANES.
REQ-025 Issue is suppressed while any lane that would be issued has outstanding = MAX_OUTST; the cadence counter holds until the stall clears.
REQ-026 Per-lane return nonce:
- Each lane k keeps a return nonce, reset on start to nonce_start+k.
- It increments by LANES on each res_valid[k].
- Each lane also keeps an outstanding counter (+1 on masked issue, -1 on res_valid); both events in the same cycle leave it unchanged.
REQ-027 A res_valid[k] while lane k has zero outstanding is ignored; no counter changes.
REQ-028 Hit capture:
- res_valid[k] & res_hit[k] in RUN or in normal DRAIN loads the pending register of lane k with the lane k return nonce.
- If that pending register is already full, the new hit is dropped and overflow is set.
REQ-029 Arbiter: each cycle the lowest-index full pending register moves to the FIFO if the FIFO is not full; a push and a pop in the same cycle are both allowed when the FIFO is full.
REQ-030 FIFO is first-word fall-through; pop when found_valid & found_ready; found_nonce is stable while found_valid is high and found_ready is low.
REQ-031 After an abort, hits are discarded, but outstanding counters keep decrementing; FIFO contents are retained.
REQ-032 Start while not IDLE is ignored; abort in IDLE or DONE is ignored; abort and start in the same cycle in IDLE: start wins.
REQ-033 An accepted start clears overflow, the pending registers and the FIFO.

Reset
REQ-034 On rst the block enters IDLE with issue=0, issue_mask=0, issue_nonce=0, found_valid=0, busy=0, done=0, overflow=0.
REQ-035 On rst all counters are cleared and the FIFO and pending registers are emptied; rst overrides every other input in the same cycle, including mid-RUN and mid-DRAIN.

Verification
REQ-036 LANES=4, THROUGHPUT=8, range 0x10..0x17, hit returned for nonce 0x15 -> exactly two issues, 8 cycles apart, nonces 0x10-0x13 then 0x14-0x17; FIFO yields 0x15; done pulses once; busy then falls.
REQ-037 Range 0xFFFFFFFE..0xFFFFFFFF -> one issue, issue_mask=0011, no wrap, done pulses.
REQ-038 Range start 5, end 3 -> no issue; done pulses 2 cycles after start.
REQ-039 All 4 lanes hit in the same cycle with found_ready=0 and FIFO_DEPTH=4 -> FIFO holds lanes 0..3 in index order; one more hit on lane 0 -> held pending; a second further hit on lane 0 -> overflow=1.
REQ-040 Abort after the first issue, hits still returning -> no further issue, no FIFO push, no done pulse; IDLE when outstanding reaches 0.
REQ-041 rst asserted mid-RUN with 3 FIFO entries -> next cycle found_valid=0, busy=0, issue=0; a following start runs normally.
